execute_unit: RTL and testbench



---
 rtl/execute_unit.sv | 217 +++++++++++++++++++++
 tb/tb_execute_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU plus optional iterative 32-cycle shift-add multiplier.
// Multiplier and its FSM are built only when EXECUTE_UNIT_MUL_EN is defined.
module execute_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [REG_AW-1:0] dest_reg,
    output logic [REG_AW-1:0] write_register,
    output logic              write_enable,
    output logic [DATA_W-1:0] write_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v,
    output logic              illegal_op
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              op_legal;
    logic              op_write;
    logic              op_mul;
    logic              accept;

    logic              we_q, we_d;
    logic              ill_q, ill_d;
    logic [REG_AW-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        flags_q, flags_d;

    assign sum_ext  = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff_ext = {1'b0, operand_a} - {1'b0, operand_b};
    assign shamt    = operand_b[4:0];

    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        op_legal = 1'b1;
        op_write = 1'b1;
        op_mul   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum_ext[DATA_W-1:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (operand_a[MSB] == operand_b[MSB]) && (alu_res[MSB] != operand_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res  = diff_ext[DATA_W-1:0];
                // Carry means "no borrow", i.e. a >= b unsigned.
                alu_c    = ~diff_ext[DATA_W];
                alu_v    = (operand_a[MSB] != operand_b[MSB]) && (alu_res[MSB] != operand_a[MSB]);
                op_write = (opcode == OP_SUB);
            end
            OP_AND: alu_res = operand_a & operand_b;
            OP_OR:  alu_res = operand_a | operand_b;
            OP_XOR: alu_res = operand_a ^ operand_b;
            OP_SLL: alu_res = operand_a << shamt;
            OP_SRL: alu_res = operand_a >> shamt;
            OP_SRA: alu_res = $signed(operand_a) >>> shamt;
            OP_MUL: begin
`ifdef EXECUTE_UNIT_MUL_EN
                op_write = 1'b0;
                op_mul   = 1'b1;
`else
                op_legal = 1'b0;
                op_write = 1'b0;
`endif
            end
            default: begin
                op_legal = 1'b0;
                op_write = 1'b0;
            end
        endcase
    end

`ifdef EXECUTE_UNIT_MUL_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [REG_AW-1:0] mdest_q, mdest_d;
    logic [DATA_W-1:0] acc_next;

    assign in_ready = (state_q == IDLE) && rst_n;
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign in_ready = rst_n;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        we_d    = 1'b0;
        ill_d   = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        flags_d = flags_q;
        if (accept) begin
            if (!op_legal) begin
                ill_d = 1'b1;
            end else if (!op_mul) begin
                flags_d = {alu_res == '0, alu_res[MSB], alu_c, alu_v};
                if (op_write) begin
                    we_d    = 1'b1;
                    wreg_d  = dest_reg;
                    wdata_d = alu_res;
                end
            end
        end
`ifdef EXECUTE_UNIT_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        mdest_d  = mdest_q;
        if (state_q == IDLE) begin
            if (accept && op_mul) begin
                state_d  = MUL;
                cnt_d    = '0;
                mcand_d  = operand_a;
                mplier_d = operand_b;
                acc_d    = '0;
                mdest_d  = dest_reg;
            end
        end else begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                state_d = IDLE;
                cnt_d   = '0;
                we_d    = 1'b1;
                wreg_d  = mdest_q;
                wdata_d = acc_next;
                flags_d = {acc_next == '0, acc_next[MSB], 2'b00};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            flags_q <= '0;
        end else begin
            we_q    <= we_d;
            ill_q   <= ill_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            flags_q <= flags_d;
        end
    end

`ifdef EXECUTE_UNIT_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mdest_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mdest_q  <= mdest_d;
        end
    end
`endif

    assign write_enable   = we_q;
    assign write_register = wreg_q;
    assign write_data     = wdata_q;
    assign illegal_op     = ill_q;
    assign flag_z         = flags_q[3];
    assign flag_n         = flags_q[2];
    assign flag_c         = flags_q[1];
    assign flag_v         = flags_q[0];

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit with a write-back scoreboard; MUL steps depend on
// EXECUTE_UNIT_MUL_EN, matching the DUT build.
module tb_execute_unit;

`ifdef EXECUTE_UNIT_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  rg;
        logic [31:0] data;
        logic [3:0]  fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  dest_reg;
    logic [3:0]  write_register;
    logic        write_enable;
    logic [31:0] write_data;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic        illegal_op;

    exp_t        sb[$];
    int          passed = 0;
    int          total = 0;
    int          pushes = 0;
    int          writes = 0;
    logic [3:0]  mflags = 4'b0000;

    always #5 clk = ~clk;

    execute_unit #(
        .DATA_W(32),
        .REG_AW(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .dest_reg      (dest_reg),
        .write_register(write_register),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .illegal_op    (illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference model built on 64-bit arithmetic.
    task automatic model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                         output logic legal, output logic wr, output logic [31:0] res,
                         output logic [3:0] fl);
        longint      sa, sb_l, sr;
        logic [63:0] wide;
        logic        c, v;
        sa    = longint'($signed(a));
        sb_l  = longint'($signed(b));
        c     = 1'b0;
        v     = 1'b0;
        res   = 32'h0;
        legal = 1'b1;
        case (opc)
            4'd0: begin
                wide = {32'b0, a} + {32'b0, b};
                res  = wide[31:0];
                c    = wide[32];
                sr   = sa + sb_l;
                v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1, 4'd9: begin
                res = a - b;
                c   = (a >= b);
                sr  = sa - sb_l;
                v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = a << b[4:0];
            4'd6: res = a >> b[4:0];
            4'd7: begin
                sr  = sa >>> b[4:0];
                res = sr[31:0];
            end
            4'd8: begin
                wide  = {32'b0, a} * {32'b0, b};
                res   = wide[31:0];
                legal = MUL_EN;
            end
            default: legal = 1'b0;
        endcase
        wr = legal && (opc != 4'd9);
        fl = {res == 32'h0, res[31], c, v};
    endtask

    task automatic push_model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] d);
        logic        legal, wr;
        logic [31:0] res;
        logic [3:0]  fl;
        model(opc, a, b, legal, wr, res, fl);
        if (legal) mflags = fl;
        if (wr) begin
            sb.push_back('{rg: d, data: res, fl: fl});
            pushes++;
        end
    endtask

    // Present one op for one cycle; returns at the negedge after its accept edge.
    task automatic issue(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d);
        opcode    = opc;
        operand_a = a;
        operand_b = b;
        dest_reg  = d;
        in_valid  = 1'b1;
        chk("ready_at_issue", 32'(in_ready), 32'd1);
        push_model(opc, a, b, d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_we"}, 32'(write_enable), 32'd0);
        chk({tag, "_reg"}, 32'(write_register), 32'd0);
        chk({tag, "_data"}, write_data, 32'd0);
        chk({tag, "_flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        chk({tag, "_ill"}, 32'(illegal_op), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && write_enable === 1'b1) begin
            writes++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(write_register), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_reg", 32'(write_register), 32'(e.rg));
                chk("wb_data", write_data, e.data);
                chk("wb_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'(e.fl));
            end
        end
    end

    initial begin
        int low_cnt;
        int wr_before;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = 4'd0;
        operand_a = 32'h0;
        operand_b = 32'h0;
        dest_reg  = 4'd0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Carry-out wrapping to zero.
        issue(4'd0, 32'hFFFF_FFFF, 32'h1, 4'd3);
        chk("add_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'b1010);
        @(negedge clk);
        chk("we_single_pulse", 32'(write_enable), 32'd0);

        // Back-to-back SUB overflow then SRA sign fill.
        issue(4'd1, 32'h8000_0000, 32'h1, 4'd4);
        issue(4'd7, 32'h8000_0000, 32'h4, 4'd5);
        chk("sra_data", write_data, 32'hF800_0000);

        for (int i = 0; i < 6; i++) begin
            issue(4'(2 + i), $urandom, $urandom, 4'(8 + i));
        end

        issue(4'd9, 32'd5, 32'd5, 4'd6);
        chk("cmp_no_write", 32'(write_enable), 32'd0);
        chk("cmp_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'(mflags));
        chk("cmp_flags_const", 32'({flag_z, flag_n, flag_c, flag_v}), 32'b1010);

        issue(4'd12, 32'h1234, 32'h5678, 4'd2);
        chk("illegal_pulse", 32'(illegal_op), 32'd1);
        chk("illegal_no_write", 32'(write_enable), 32'd0);
        chk("illegal_flags_hold", 32'({flag_z, flag_n, flag_c, flag_v}), 32'b1010);
        @(negedge clk);
        chk("illegal_pulse_end", 32'(illegal_op), 32'd0);

`ifdef EXECUTE_UNIT_MUL_EN
        issue(4'd8, 32'h0001_0001, 32'h0001_0001, 4'd7);
        opcode    = 4'd0;
        operand_a = 32'h10;
        operand_b = 32'h20;
        dest_reg  = 4'd2;
        in_valid  = 1'b1;
        low_cnt   = 0;
        for (int i = 0; i < 40 && in_ready !== 1'b1; i++) begin
            low_cnt++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", 32'(low_cnt), 32'd32);
        chk("mul_data", write_data, 32'h0002_0001);
        push_model(4'd0, 32'h10, 32'h20, 4'd2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_mul_accept", write_data, 32'h30);

        // Abort a multiply at its tenth cycle.
        issue(4'd8, 32'hDEAD_BEEF, 32'h0000_0003, 4'd9);
        wr_before = writes;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("mul_abort");
        sb.delete();
        pushes--;
        mflags = 4'b0000;
        repeat (40) @(negedge clk);
        chk("abort_no_write", 32'(writes), 32'(wr_before));
        rst_n = 1'b1;
        @(negedge clk);
`else
        issue(4'd8, 32'h0001_0001, 32'h0001_0001, 4'd7);
        chk("mul_off_illegal", 32'(illegal_op), 32'd1);
        chk("mul_off_no_write", 32'(write_enable), 32'd0);
        chk("mul_off_ready", 32'(in_ready), 32'd1);
        low_cnt   = 0;
        wr_before = writes;
        rst_n     = 1'b0;
        #1;
        chk_zero_outputs("reset2");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset2_writes", 32'(writes), 32'(wr_before + low_cnt));
`endif
        issue(4'd0, 32'd2, 32'd3, 4'd1);
        chk("add_after_reset", write_data, 32'd5);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("write_count", 32'(writes), 32'(pushes));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
